truth_table_sequencer: RTL

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps a 3-input function through all 8 vectors,
// captures its truth table and compares it against a golden table.
`default_nettype none

module truth_table_sequencer #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   input  logic       s1,
   output logic       x,
   output logic       y,
   output logic       z,
   output logic       busy,
   output logic       done,
   output logic [7:0] tt,
   output logic [3:0] ones,
   output logic       mismatch,
   output logic [7:0] diff
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [2:0] index;
   logic [3:0] counter;
   logic [7:0] expected_cap;
   logic [7:0] tt_sampled;
   logic       settle_last;
   logic       accept;

   assign accept      = (state == IDLE) && start && !abort;
   assign settle_last = (counter == 4'(SETTLE - 1));
   assign busy        = (state == DRIVE) || (state == SAMPLE);
   assign done        = (state == DONE);
   assign {x, y, z}   = busy ? index : 3'd0;

   // Truth table as it will look once the current vector's s1 is stored.
   always_comb begin
      tt_sampled        = tt;
      tt_sampled[index] = s1;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = DRIVE;
         DRIVE: begin
            if (abort)            state_next = IDLE;
            else if (settle_last) state_next = SAMPLE;
         end
         SAMPLE: begin
            if (abort)              state_next = IDLE;
            else if (index == 3'd7) state_next = DONE;
            else                    state_next = DRIVE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         index        <= 3'd0;
         counter      <= 4'd0;
         expected_cap <= 8'd0;
         tt           <= 8'd0;
         ones         <= 4'd0;
         mismatch     <= 1'b0;
         diff         <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  index        <= 3'd0;
                  counter      <= 4'd0;
                  expected_cap <= expected;
                  tt           <= 8'd0;
                  ones         <= 4'd0;
                  mismatch     <= 1'b0;
                  diff         <= 8'd0;
               end
            end
            DRIVE, SAMPLE: begin
               if (abort) begin
                  index    <= 3'd0;
                  counter  <= 4'd0;
                  tt       <= 8'd0;
                  ones     <= 4'd0;
                  mismatch <= 1'b0;
                  diff     <= 8'd0;
               end else if (state == DRIVE) begin
                  counter <= counter + 4'd1;
               end else begin
                  tt      <= tt_sampled;
                  ones    <= ones + {3'd0, s1};
                  counter <= 4'd0;
                  // Compare on the final sample so results are valid in DONE.
                  if (index == 3'd7) begin
                     diff     <= tt_sampled ^ expected_cap;
                     mismatch <= (tt_sampled != expected_cap);
                  end else begin
                     index <= index + 3'd1;
                  end
               end
            end
            DONE: begin
               index   <= 3'd0;
               counter <= 4'd0;
            end
            default: begin
               index   <= 3'd0;
               counter <= 4'd0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
